// File: rtl/pipe_ctrl_gen.sv
// Pipeline hazard/exception controller: merges stage stall requests, drives a
// multi-cycle flush with a latched exception vector, and runs a stall watchdog.
module pipe_ctrl_gen #(
  parameter int              NSTAGE       = 5,
  parameter int              DW           = 32,
  parameter logic [DW-1:0]   EXC_BASE     = '0,
  parameter int              FLUSH_CYCLES = 1,
  parameter int              DSLOT_KEEP   = 1,
  parameter int              CW           = 16,
  parameter int              TIMEOUT      = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NSTAGE-1:0] stallreq_i,
  input  logic              excep_valid_i,
  input  logic [4:0]        excep_code_i,
  input  logic [DW-1:0]     cp0_epc_i,
  output logic [NSTAGE:0]   stall_o,
  output logic              flush_o,
  output logic [DW-1:0]     excep_vector_o,
  output logic [CW-1:0]     stall_cnt_o,
  output logic              timeout_o,
  input  logic              timeout_clr_i
);

  localparam int            FW         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);
  localparam logic [DW-1:0] VEC_INT    = EXC_BASE + DW'(32'h20);
  localparam logic [DW-1:0] VEC_GEN    = EXC_BASE + DW'(32'h40);
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ARM    = CW'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t        r_state;
  logic [FW-1:0] r_fcnt;
  logic [DW-1:0] r_vec;
  logic [CW-1:0] r_cnt;
  logic          r_timeout;

  logic [NSTAGE-1:0] w_any_ge;
  logic [NSTAGE:0]   w_merge;
  logic              w_accept;
  logic              w_flush;
  logic              w_stalled;
  logic              w_to_set;
  logic [DW-1:0]     w_vec_sel;

  // w_any_ge[i]: some stage at or beyond i requests a stall.
  genvar gi;
  generate
    for (gi = 0; gi < NSTAGE; gi++) begin : g_any
      assign w_any_ge[gi] = |stallreq_i[NSTAGE-1:gi];
    end

    assign w_merge[0] = w_any_ge[0];
    for (gi = 1; gi <= NSTAGE; gi++) begin : g_bit
      if (gi == 2 && DSLOT_KEEP != 0) begin : g_dslot
        assign w_merge[gi] = w_any_ge[0];
      end else begin : g_plain
        assign w_merge[gi] = w_any_ge[gi-1];
      end
    end
  endgenerate

  always_comb begin
    w_vec_sel = VEC_GEN;
    case (excep_code_i)
      5'h01:   w_vec_sel = VEC_INT;
      5'h0e:   w_vec_sel = cp0_epc_i;
      default: w_vec_sel = VEC_GEN;
    endcase
  end

  assign w_accept = excep_valid_i && (r_state == S_IDLE);
  assign w_flush  = w_accept || (r_state == S_FLUSH);

  assign flush_o        = rst_n && w_flush;
  assign stall_o        = (rst_n && !w_flush) ? w_merge : '0;
  assign excep_vector_o = !rst_n ? '0 : (w_accept ? w_vec_sel : r_vec);
  assign stall_cnt_o    = r_cnt;
  assign timeout_o      = r_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_fcnt  <= '0;
      r_vec   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_vec <= w_vec_sel;
            if (FLUSH_CYCLES > 1) begin
              r_state <= S_FLUSH;
              r_fcnt  <= FLUSH_LOAD;
            end
          end
        end
        S_FLUSH: begin
          r_fcnt <= r_fcnt - FW'(1);
          if (r_fcnt == FW'(1)) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // stall_o is already forced to zero during flush, so it alone qualifies a stalled cycle.
  assign w_stalled = (stall_o != '0);
  assign w_to_set  = w_stalled && (r_cnt == CNT_ARM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_stalled) begin
        if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
      if (w_to_set) begin
        r_timeout <= 1'b1;
      end else if (timeout_clr_i) begin
        r_timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Bench for pipe_ctrl_gen: two configurations checked every cycle against a
// behavioural model, plus directed literal expectations.
module tb_pipe_ctrl_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [4:0]  req;
  logic        valid;
  logic [4:0]  code;
  logic [31:0] epc;
  logic        clr;

  logic [5:0]  st_a;
  logic        fl_a;
  logic [31:0] vec_a;
  logic [3:0]  cnt_a;
  logic        to_a;
  logic [4:0]  st_b;
  logic        fl_b;
  logic [31:0] vec_b;
  logic [2:0]  cnt_b;
  logic        to_b;

  pipe_ctrl_gen #(
    .NSTAGE(5), .DW(32), .EXC_BASE(32'h0), .FLUSH_CYCLES(3),
    .DSLOT_KEEP(1), .CW(4), .TIMEOUT(4)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .stallreq_i(req), .excep_valid_i(valid),
    .excep_code_i(code), .cp0_epc_i(epc), .stall_o(st_a), .flush_o(fl_a),
    .excep_vector_o(vec_a), .stall_cnt_o(cnt_a), .timeout_o(to_a),
    .timeout_clr_i(clr)
  );

  pipe_ctrl_gen #(
    .NSTAGE(4), .DW(32), .EXC_BASE(32'hFFFF_FFF0), .FLUSH_CYCLES(1),
    .DSLOT_KEEP(0), .CW(3), .TIMEOUT(6)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .stallreq_i(req[3:0]), .excep_valid_i(valid),
    .excep_code_i(code), .cp0_epc_i(epc), .stall_o(st_b), .flush_o(fl_b),
    .excep_vector_o(vec_b), .stall_cnt_o(cnt_b), .timeout_o(to_b),
    .timeout_clr_i(clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Configuration table for the two instances.
  int          P_N   [2] = '{5, 4};
  int          P_FC  [2] = '{3, 1};
  int          P_DS  [2] = '{1, 0};
  int          P_CW  [2] = '{4, 3};
  int          P_TO  [2] = '{4, 6};
  logic [31:0] P_BASE[2] = '{32'h0, 32'hFFFF_FFF0};

  // Model state: remaining flush cycles after the current one, captured vector,
  // consecutive stall count, sticky flag.
  int          m_left[2];
  logic [31:0] m_cap [2];
  int          m_cnt [2];
  logic        m_to  [2];

  function automatic logic [5:0] merge_f(input logic [4:0] r, input int n, input int ds);
    int         j = -1;
    int         hi;
    logic [5:0] m = '0;
    for (int i = 0; i < n; i++) if (r[i]) j = i;
    if (j < 0) return '0;
    hi = (j + 1 > n) ? n : j + 1;
    if (j == 0 && ds != 0) hi = (n < 2) ? n : 2;
    for (int b = 0; b <= hi; b++) m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] sel_f(input logic [4:0] c, input logic [31:0] e,
                                        input logic [31:0] base);
    if (c == 5'h01) return base + 32'h20;
    if (c == 5'h0e) return e;
    return base + 32'h40;
  endfunction

  task automatic model_step(input int k);
    logic [5:0]  a_st;
    logic        a_fl;
    logic [31:0] a_vec;
    logic [31:0] a_cnt;
    logic        a_to;
    logic [5:0]  e_st = '0;
    logic        e_fl = 1'b0;
    logic [31:0] e_vec = '0;
    logic [31:0] sel = '0;
    logic        acc = 1'b0;
    logic        in_fl = 1'b0;
    logic        stalled;
    logic        set;
    int          mx;
    string       p;
    if (k == 0) begin
      a_st = st_a; a_fl = fl_a; a_vec = vec_a; a_cnt = {28'b0, cnt_a}; a_to = to_a; p = "A";
    end else begin
      a_st = {1'b0, st_b}; a_fl = fl_b; a_vec = vec_b; a_cnt = {29'b0, cnt_b}; a_to = to_b; p = "B";
    end
    mx = (1 << P_CW[k]) - 1;
    if (!rst_n) begin
      m_left[k] = 0; m_cap[k] = '0; m_cnt[k] = 0; m_to[k] = 1'b0;
    end else begin
      in_fl = (m_left[k] > 0);
      acc   = valid && !in_fl;
      e_fl  = acc || in_fl;
      sel   = sel_f(code, epc, P_BASE[k]);
      e_vec = acc ? sel : m_cap[k];
      e_st  = e_fl ? 6'd0 : merge_f((k == 0) ? req : {1'b0, req[3:0]}, P_N[k], P_DS[k]);
    end
    chk({p, ".stall"},   32'(a_st), 32'(e_st));
    chk({p, ".flush"},   32'(a_fl), 32'(e_fl));
    chk({p, ".vector"},  a_vec,     e_vec);
    chk({p, ".cnt"},     a_cnt,     32'(m_cnt[k]));
    chk({p, ".timeout"}, 32'(a_to), 32'(m_to[k]));
    if (rst_n) begin
      stalled = (e_st != 6'd0);
      set     = stalled && (m_cnt[k] < mx) && (m_cnt[k] + 1 == P_TO[k]);
      if (acc) begin
        m_left[k] = P_FC[k] - 1;
        m_cap[k]  = sel;
      end else if (in_fl) begin
        m_left[k] = m_left[k] - 1;
      end
      m_to[k]  = set ? 1'b1 : (clr ? 1'b0 : m_to[k]);
      m_cnt[k] = stalled ? ((m_cnt[k] < mx) ? m_cnt[k] + 1 : mx) : 0;
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  task automatic nedge();
    @(negedge clk);
  endtask

  task automatic pedge();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] tv_req[6] = '{5'b00100, 5'b00010, 5'b00001, 5'b01000, 5'b01101, 5'b00000};
  logic [5:0] tv_a  [6] = '{6'b001111, 6'b000111, 6'b000111, 6'b011111, 6'b011111, 6'b000000};
  logic [4:0] tv_b  [6] = '{5'b01111, 5'b00111, 5'b00011, 5'b11111, 5'b11111, 5'b00000};

  initial begin
    rst_n = 1'b1; req = 5'b00100; valid = 1'b1; code = 5'h01; epc = '0; clr = 1'b0;
    #1 rst_n = 1'b0;
    nedge();
    chk("rst.stall_gated", 32'(st_a), 32'h0);
    chk("rst.flush_gated", 32'(fl_a), 32'h0);
    chk("rst.vec_gated",   vec_a,     32'h0);
    pedge();
    rst_n = 1'b1; req = '0; valid = 1'b0;

    // Stall merge table.
    for (int i = 0; i < 6; i++) begin
      req = tv_req[i];
      nedge();
      chk("merge.A", 32'(st_a), 32'(tv_a[i]));
      chk("merge.B", 32'(st_b), 32'(tv_b[i]));
      pedge();
    end
    clr = 1'b1;
    nedge(); pedge();
    clr = 1'b0;

    // Flush length, ignored and accepted back-to-back exceptions, ERET capture.
    valid = 1'b1; code = 5'h01;
    nedge();
    chk("fl0.flush", 32'(fl_a), 32'h1); chk("fl0.vec", vec_a, 32'h20);
    chk("fl0.vecB", vec_b, 32'h10);
    pedge();
    valid = 1'b0;
    nedge(); chk("fl1.flush", 32'(fl_a), 32'h1); chk("fl1.vec", vec_a, 32'h20); pedge();
    valid = 1'b1; code = 5'h0e; epc = 32'h999;
    nedge(); chk("fl2.flush", 32'(fl_a), 32'h1); chk("fl2.ignored", vec_a, 32'h20); pedge();
    epc = 32'h1234;
    nedge(); chk("fl3.accept", 32'(fl_a), 32'h1); chk("fl3.eret", vec_a, 32'h1234); pedge();
    valid = 1'b0; epc = 32'h5678;
    nedge(); chk("fl4.flush", 32'(fl_a), 32'h1); chk("fl4.held", vec_a, 32'h1234); pedge();
    nedge(); chk("fl5.flush", 32'(fl_a), 32'h1); chk("fl5.held", vec_a, 32'h1234); pedge();
    nedge(); chk("fl6.idle", 32'(fl_a), 32'h0); chk("fl6.hold", vec_a, 32'h1234); pedge();
    valid = 1'b1; code = 5'h0c;
    nedge(); chk("code0c.vec", vec_a, 32'h40); chk("code0c.vecB", vec_b, 32'h30); pedge();
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin nedge(); pedge(); end
    valid = 1'b1; code = 5'h1f;
    nedge(); chk("code1f.vec", vec_a, 32'h40); pedge();
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin nedge(); pedge(); end

    // Flush overrides stall.
    req = 5'b00100; valid = 1'b1; code = 5'h08;
    nedge(); chk("ovr0.stall", 32'(st_a), 32'h0); chk("ovr0.flush", 32'(fl_a), 32'h1); pedge();
    valid = 1'b0;
    nedge(); chk("ovr1.stall", 32'(st_a), 32'h0); pedge();
    nedge(); chk("ovr2.stall", 32'(st_a), 32'h0); pedge();
    nedge(); chk("ovr3.stall", 32'(st_a), 32'h0f); chk("ovr3.flush", 32'(fl_a), 32'h0); pedge();

    // Watchdog count and sticky flag.
    req = '0; clr = 1'b1;
    nedge(); pedge();
    clr = 1'b0;
    nedge(); chk("wd.cnt_clear", 32'(cnt_a), 32'h0); chk("wd.to_clear", 32'(to_a), 32'h0); pedge();
    req = 5'b00100;
    for (int i = 0; i < 6; i++) begin
      nedge();
      chk("wd.cnt", 32'(cnt_a), 32'(i));
      chk("wd.to", 32'(to_a), (i >= 4) ? 32'h1 : 32'h0);
      pedge();
    end
    req = '0;
    nedge(); chk("wd.cnt6", 32'(cnt_a), 32'h6); chk("wd.to_sticky", 32'(to_a), 32'h1); pedge();
    nedge(); chk("wd.release", 32'(cnt_a), 32'h0); chk("wd.to_sticky2", 32'(to_a), 32'h1); pedge();
    clr = 1'b1;
    nedge(); chk("wd.to_before_clr", 32'(to_a), 32'h1); pedge();
    clr = 1'b0;
    nedge(); chk("wd.to_cleared", 32'(to_a), 32'h0); pedge();

    // Set beats a simultaneous clear; counters saturate.
    clr = 1'b1; req = 5'b00100;
    for (int i = 0; i < 20; i++) begin
      nedge();
      if (i == 4) chk("sat.setwins.A", 32'(to_a), 32'h1);
      if (i == 5) chk("sat.clr.A",     32'(to_a), 32'h0);
      if (i == 6) chk("sat.setwins.B", 32'(to_b), 32'h1);
      if (i == 7) chk("sat.clr.B",     32'(to_b), 32'h0);
      pedge();
    end
    nedge(); chk("sat.cntA", 32'(cnt_a), 32'hf); chk("sat.cntB", 32'(cnt_b), 32'h7); pedge();
    req = '0; clr = 1'b0;
    nedge(); pedge();

    // Reset in the middle of a flush.
    valid = 1'b1; code = 5'h01;
    nedge(); pedge();
    valid = 1'b0;
    nedge(); pedge();
    #2;
    rst_n = 1'b0; req = 5'b00100; valid = 1'b1;
    #1;
    chk("mrst.flush", 32'(fl_a),  32'h0);
    chk("mrst.vec",   vec_a,      32'h0);
    chk("mrst.stall", 32'(st_a),  32'h0);
    chk("mrst.cnt",   32'(cnt_a), 32'h0);
    chk("mrst.to",    32'(to_a),  32'h0);
    nedge(); pedge();
    rst_n = 1'b1; valid = 1'b0; req = '0;
    nedge(); chk("mrst.after0", 32'(fl_a), 32'h0); chk("mrst.vec0", vec_a, 32'h0); pedge();
    nedge(); chk("mrst.after1", 32'(fl_a), 32'h0); pedge();
    valid = 1'b1; code = 5'h01;
    nedge(); chk("mrst.new_exc", 32'(fl_a), 32'h1); chk("mrst.new_vec", vec_a, 32'h20); pedge();
    valid = 1'b0;
    for (int i = 0; i < 4; i++) begin nedge(); pedge(); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
